// File: rtl/vproc64_mem_responder.sv
// Bus-slave RAM for a VProc64 initiator: single and burst read/write beats with
// programmable wait states, byte-enabled writes and sticky range/protocol flags.
module vproc64_mem_responder #(
  parameter int unsigned MEM_WORDS_LOG2 = 12,
  parameter logic [63:0] BASE_ADDR      = 64'h0,
  parameter int unsigned ADDR_LSB       = 3,
  parameter int unsigned RD_WAIT        = 0,
  parameter int unsigned WR_WAIT        = 0
) (
  input  logic        Clk,
  input  logic        nReset,
  input  logic [63:0] Addr,
  input  logic [7:0]  BE,
  input  logic        WE,
  input  logic        RD,
  input  logic [63:0] WrData,
  output logic [63:0] RdData,
  output logic        WRAck,
  output logic        RDAck,
  input  logic [11:0] Burst,
  input  logic        BurstFirst,
  input  logic        BurstLast,
  output logic        RangeErr,
  output logic        ProtErr,
  output logic [1:0]  dbg_state
);

  // Handshake: the initiator holds WE or RD (with Addr/WrData/BE) until it sees a
  // one-cycle WRAck/RDAck; dropping the request before the ack abandons the beat.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  localparam int unsigned MEM_WORDS = 1 << MEM_WORDS_LOG2;
  localparam logic [7:0]  RD_WAIT_C = 8'(RD_WAIT);
  localparam logic [7:0]  WR_WAIT_C = 8'(WR_WAIT);

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [7:0]  wait_load;
  logic [63:0] rd_data_q, rd_data_d;
  logic        wr_ack_q, wr_ack_d;
  logic        rd_ack_q, rd_ack_d;
  logic        range_err_q, range_err_d;
  logic        prot_err_q, prot_err_d;
  logic        burst_open_q, burst_open_d;
  logic [11:0] beat_cnt_q, beat_cnt_d;
  logic [11:0] burst_len_q, burst_len_d;
  logic [11:0] cnt_now, len_now;
  logic        enter_ack;
  logic        mem_we;

  logic [63:0] offset, idx_full;
  logic [MEM_WORDS_LOG2-1:0] idx;
  logic        in_range;

  logic [63:0] mem [MEM_WORDS];

  // The subtraction wraps for Addr < BASE_ADDR, so that case is rejected explicitly.
  assign offset   = Addr - BASE_ADDR;
  assign idx_full = offset >> ADDR_LSB;
  assign idx      = idx_full[MEM_WORDS_LOG2-1:0];
  assign in_range = (Addr >= BASE_ADDR) && (idx_full[63:MEM_WORDS_LOG2] == '0);

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q      <= ST_IDLE;
      wait_q       <= 8'd0;
      rd_data_q    <= 64'h0;
      wr_ack_q     <= 1'b0;
      rd_ack_q     <= 1'b0;
      range_err_q  <= 1'b0;
      prot_err_q   <= 1'b0;
      burst_open_q <= 1'b0;
      beat_cnt_q   <= 12'd0;
      burst_len_q  <= 12'd0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      rd_data_q    <= rd_data_d;
      wr_ack_q     <= wr_ack_d;
      rd_ack_q     <= rd_ack_d;
      range_err_q  <= range_err_d;
      prot_err_q   <= prot_err_d;
      burst_open_q <= burst_open_d;
      beat_cnt_q   <= beat_cnt_d;
      burst_len_q  <= burst_len_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    wait_load = WE ? WR_WAIT_C : RD_WAIT_C;
    case (state_q)
      ST_IDLE: begin
        if (WE || RD) begin
          if (wait_load == 8'd0) begin
            state_d = ST_ACK;
          end else begin
            state_d = ST_WAIT;
            wait_d  = wait_load;
          end
        end
      end
      ST_WAIT: begin
        if (!(WE || RD)) begin
          state_d = ST_IDLE;
          wait_d  = 8'd0;
        end else begin
          wait_d = wait_q - 8'd1;
          if (wait_q == 8'd1) state_d = ST_ACK;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ACK always returns to IDLE, so state_d==ACK marks exactly the edge entering ACK.
  assign enter_ack = (state_d == ST_ACK);

  always_comb begin
    rd_data_d    = rd_data_q;
    wr_ack_d     = 1'b0;
    rd_ack_d     = 1'b0;
    range_err_d  = range_err_q;
    prot_err_d   = prot_err_q;
    burst_open_d = burst_open_q;
    beat_cnt_d   = beat_cnt_q;
    burst_len_d  = burst_len_q;
    cnt_now      = beat_cnt_q + 12'd1;
    len_now      = burst_len_q;
    mem_we       = 1'b0;
    if (enter_ack) begin
      wr_ack_d = WE;
      rd_ack_d = !WE;
      if (!in_range) range_err_d = 1'b1;
      if (WE && RD) prot_err_d = 1'b1;
      if (WE) mem_we = in_range;
      else    rd_data_d = in_range ? mem[idx] : 64'h0;
      if (Burst != 12'd0) begin
        if (BurstFirst) begin
          if (burst_open_q) prot_err_d = 1'b1;
          len_now = Burst;
          cnt_now = 12'd1;
        end
        if (BurstFirst || burst_open_q) begin
          beat_cnt_d   = cnt_now;
          burst_len_d  = len_now;
          burst_open_d = 1'b1;
          if (BurstLast) begin
            if (cnt_now != len_now) prot_err_d = 1'b1;
            burst_open_d = 1'b0;
          end
        end
      end
    end
  end

  // RAM has no reset: contents survive nReset.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      for (int n = 0; n < 8; n++) begin
        if (BE[n]) mem[idx][8*n +: 8] <= WrData[8*n +: 8];
      end
    end
  end

  assign RdData    = rd_data_q;
  assign WRAck     = wr_ack_q;
  assign RDAck     = rd_ack_q;
  assign RangeErr  = range_err_q;
  assign ProtErr   = prot_err_q;
  assign dbg_state = state_q;

endmodule
